// File: rtl/vrased_pkg.sv
// Shared VRASED definitions: controller state encoding and the memory-map
// constants that the access monitors also use.
package vrased_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ASSERT    = 2'd1,
      WAIT_BOOT = 2'd2
   } state_t;

   localparam logic [15:0] RESET_HANDLER = 16'hFFFE;
   localparam logic [15:0] SMEM_BASE     = 16'hE000;
   localparam logic [15:0] SMEM_SIZE     = 16'h1000;

endpackage

// File: rtl/vrased_sat_cnt.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module vrased_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Increment on request unless already at the maximum value.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/vrased_reset_ctrl.sv
// VRASED reset controller: turns monitor violation requests into a CPU reset
// of guaranteed length, then watches for the CPU to fetch the reset vector
// before re-arming. Keeps a sticky cause and an episode count for attestation.
//
// Handshake: there is no valid/ready pair here. viol_req bits are levels;
// any set bit in IDLE or WAIT_BOOT starts a reset episode on the next edge,
// and a request seen while already in ASSERT is only recorded in cause.
module vrased_reset_ctrl
   import vrased_pkg::*;
#(
   parameter int          NSRC         = 2,
   parameter logic [15:0] HOLD_CYCLES  = 16'd8,
   parameter logic [15:0] BOOT_TIMEOUT = 16'd64
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NSRC-1:0] viol_req,
   input  logic [15:0]     pc,
   input  logic            cause_clr,
   output logic            cpu_reset,
   output logic            busy,
   output logic [NSRC-1:0] cause,
   output logic [7:0]      viol_cnt,
   output logic            boot_fail,
   output state_t          state_dbg
);

   localparam logic [15:0] SROM_LAST = SMEM_BASE + SMEM_SIZE - 16'd2;

   state_t      state, state_nxt;
   logic [15:0] counter, counter_nxt;
   logic        cpu_reset_nxt;
   logic        boot_fail_nxt;
   logic        episode_start;
   logic        any_viol;
   logic        pc_in_srom;

   assign any_viol   = |viol_req;
   assign pc_in_srom = (pc >= SMEM_BASE) && (pc <= SROM_LAST);
   assign state_dbg  = state;

   // Next-state and next-output decode for the reset episode FSM.
   always_comb begin
      state_nxt     = state;
      counter_nxt   = counter;
      cpu_reset_nxt = cpu_reset;
      boot_fail_nxt = boot_fail;
      episode_start = 1'b0;
      case (state)
         IDLE: begin
            cpu_reset_nxt = 1'b0;
            if (any_viol) begin
               state_nxt     = ASSERT;
               counter_nxt   = HOLD_CYCLES - 16'd1;
               cpu_reset_nxt = 1'b1;
               episode_start = 1'b1;
            end
         end
         ASSERT: begin
            cpu_reset_nxt = 1'b1;
            if (counter == 16'd0) begin
               state_nxt     = WAIT_BOOT;
               counter_nxt   = BOOT_TIMEOUT - 16'd1;
               cpu_reset_nxt = 1'b0;
            end else begin
               counter_nxt = counter - 16'd1;
            end
         end
         WAIT_BOOT: begin
            cpu_reset_nxt = 1'b0;
            // A fresh violation outranks a matching reset-vector fetch.
            if (any_viol) begin
               state_nxt     = ASSERT;
               counter_nxt   = HOLD_CYCLES - 16'd1;
               cpu_reset_nxt = 1'b1;
               episode_start = 1'b1;
            end else if (pc == RESET_HANDLER) begin
               state_nxt = IDLE;
            end else if (counter == 16'd0) begin
               state_nxt     = ASSERT;
               counter_nxt   = HOLD_CYCLES - 16'd1;
               cpu_reset_nxt = 1'b1;
               boot_fail_nxt = 1'b1;
               episode_start = 1'b1;
            end else begin
               counter_nxt = counter - 16'd1;
            end
         end
         default: begin
            state_nxt     = IDLE;
            counter_nxt   = 16'd0;
            cpu_reset_nxt = 1'b0;
         end
      endcase
   end

   // FSM state, hold/timeout counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         counter   <= 16'd0;
         cpu_reset <= 1'b0;
         busy      <= 1'b0;
         boot_fail <= 1'b0;
      end else begin
         state     <= state_nxt;
         counter   <= counter_nxt;
         cpu_reset <= cpu_reset_nxt;
         busy      <= (state_nxt != IDLE);
         boot_fail <= boot_fail_nxt;
      end
   end

   // Sticky cause; a clear from secure ROM still keeps same-cycle requests.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cause <= '0;
      end else if (cause_clr && pc_in_srom) begin
         cause <= viol_req;
      end else begin
         cause <= cause | viol_req;
      end
   end

   vrased_sat_cnt #(.W(8)) u_viol_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (episode_start),
      .count   (viol_cnt)
   );

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Directed bench for vrased_reset_ctrl with hand-computed expectations.
module tb_vrased_reset_ctrl;
   import vrased_pkg::*;

   logic        clk;
   logic        reset_n;
   logic [1:0]  viol_req;
   logic [15:0] pc;
   logic        cause_clr;
   logic        cpu_reset;
   logic        busy;
   logic [1:0]  cause;
   logic [7:0]  viol_cnt;
   logic        boot_fail;
   state_t      state_dbg;

   int checks   = 0;
   int failures = 0;
   int hi;

   vrased_reset_ctrl dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .viol_req  (viol_req),
      .pc        (pc),
      .cause_clr (cause_clr),
      .cpu_reset (cpu_reset),
      .busy      (busy),
      .cause     (cause),
      .viol_cnt  (viol_cnt),
      .boot_fail (boot_fail),
      .state_dbg (state_dbg)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; sample and drive 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Hold cycles after the entry edge (7) plus the release edge.
   task automatic finish_hold();
      repeat (7) tick();
      tick();
   endtask

   initial begin
      reset_n   = 1'b0;
      viol_req  = 2'b00;
      pc        = 16'h4000;
      cause_clr = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      check("rst_cpu_reset", cpu_reset, 0);
      check("rst_busy", busy, 0);
      check("rst_cause", cause, 0);
      check("rst_viol_cnt", viol_cnt, 0);
      check("rst_boot_fail", boot_fail, 0);
      check("rst_state", state_dbg, IDLE);

      // Single violation, with an extra request mid-hold that must not extend it
      viol_req = 2'b01;
      tick();
      viol_req = 2'b00;
      check("v1_cpu_reset", cpu_reset, 1);
      check("v1_busy", busy, 1);
      check("v1_cnt", viol_cnt, 1);
      check("v1_cause", cause, 2'b01);
      hi = 1;
      for (int i = 0; i < 7; i++) begin
         if (i == 2) viol_req = 2'b01;
         tick();
         viol_req = 2'b00;
         if (cpu_reset) hi++;
      end
      check("v1_hold_len", hi, 8);
      check("v1_cnt_no_bump", viol_cnt, 1);
      tick();
      check("v1_release", cpu_reset, 0);
      check("v1_wait_state", state_dbg, WAIT_BOOT);
      check("v1_wait_busy", busy, 1);
      pc = 16'hFFFE;
      tick();
      check("v1_idle_busy", busy, 0);
      check("v1_idle_state", state_dbg, IDLE);
      check("v1_idle_cause", cause, 2'b01);
      check("v1_idle_cnt", viol_cnt, 1);
      pc = 16'h4000;

      // Violation in WAIT_BOOT wins over a simultaneous reset-vector fetch
      viol_req = 2'b10;
      tick();
      viol_req = 2'b00;
      check("v2_cnt", viol_cnt, 2);
      finish_hold();
      check("v2_release", cpu_reset, 0);
      viol_req = 2'b10;
      pc       = 16'hFFFE;
      tick();
      viol_req = 2'b00;
      pc       = 16'h4000;
      check("v2_reassert", cpu_reset, 1);
      check("v2_state", state_dbg, ASSERT);
      check("v2_cause", cause, 2'b11);
      check("v2_cnt_after", viol_cnt, 3);
      hi = 1;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (cpu_reset) hi++;
      end
      check("v2_hold_len", hi, 8);
      tick();
      check("v2_release2", cpu_reset, 0);

      // Boot timeout: 64 cycles in WAIT_BOOT without the reset vector
      repeat (63) tick();
      check("to_still_wait", state_dbg, WAIT_BOOT);
      check("to_no_fail_yet", boot_fail, 0);
      tick();
      check("to_boot_fail", boot_fail, 1);
      check("to_reassert", cpu_reset, 1);
      check("to_cnt", viol_cnt, 4);
      finish_hold();
      pc = 16'hFFFE;
      tick();
      pc = 16'h4000;
      check("to_back_idle", state_dbg, IDLE);
      check("to_fail_sticky", boot_fail, 1);

      // Cause clear honoured only from secure ROM
      cause_clr = 1'b1;
      pc        = 16'h4000;
      tick();
      check("clr_outside", cause, 2'b11);
      pc = 16'hE100;
      tick();
      check("clr_inside", cause, 2'b00);
      viol_req = 2'b01;
      tick();
      viol_req  = 2'b00;
      cause_clr = 1'b0;
      check("clr_new_wins", cause, 2'b01);
      check("clr_cnt", viol_cnt, 5);
      pc = 16'h4000;
      finish_hold();
      pc = 16'hFFFE;
      tick();
      cause_clr = 1'b1;
      pc        = 16'hEFFF;
      tick();
      check("clr_above_top", cause, 2'b01);
      pc = 16'hEFFE;
      tick();
      check("clr_top_edge", cause, 2'b00);
      cause_clr = 1'b0;
      pc        = 16'h4000;

      // Saturation of the episode counter over 300 episodes
      for (int e = 0; e < 300; e++) begin
         viol_req = 2'($urandom_range(1, 3));
         tick();
         viol_req = 2'b00;
         finish_hold();
         pc = 16'hFFFE;
         tick();
         pc = 16'h4000;
         if (e == 248) check("sat_fe", viol_cnt, 8'hFE);
      end
      check("sat_ff", viol_cnt, 8'hFF);
      check("sat_idle", state_dbg, IDLE);

      // Reset abort in the middle of a hold
      viol_req = 2'b01;
      tick();
      viol_req = 2'b00;
      tick();
      tick();
      check("ab_holding", cpu_reset, 1);
      reset_n = 1'b0;
      tick();
      check("ab_cpu_reset", cpu_reset, 0);
      check("ab_state", state_dbg, IDLE);
      check("ab_busy", busy, 0);
      check("ab_cnt", viol_cnt, 0);
      check("ab_cause", cause, 0);
      check("ab_boot_fail", boot_fail, 0);
      reset_n = 1'b1;
      tick();
      check("ab_stays_idle", state_dbg, IDLE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
